// File: rtl/ttest_mul_arb_if.sv
// Request/response bundle for the shared 32x8 multiplier arbiter.
// The arbiter is the slave; the requester side is the master.
interface ttest_mul_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0]  req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [39:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           issue_cnt;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, issue_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, issue_cnt
  );
endinterface

// File: rtl/ttest_mul_arb.sv
// Round-robin arbiter in front of one pipelined 32x8 unsigned multiplier.
// One operation per cycle; the response stage stalls on rsp_ready.
module ttest_mul_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic             clk,
  input logic             reset,
  ttest_mul_arb_if.slave  bus
);

  logic              rsp_valid_q, rsp_valid_d;
  logic [39:0]       prod_q, prod_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic              ce;
  logic              hs;
  logic [31:0]       a_sel;
  logic [7:0]        b_sel;
  int                idx;

  assign ce = ~rsp_valid_q | bus.rsp_ready;

  // Scan from ptr upward with wrap; first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign hs    = found & ce & ~reset;
  assign a_sel = bus.req_a[win*32 +: 32];
  assign b_sel = bus.req_b[win*8 +: 8];

  always_comb begin
    bus.req_ready = '0;
    if (hs) bus.req_ready[win] = 1'b1;
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    prod_d      = {8'd0, a_sel} * {32'd0, b_sel};
    if (ce) begin
      rsp_valid_d = found;
      id_d        = win;
    end
    if (hs) begin
      ptr_d = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      id_q        <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Product register is masked by rsp_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (ce) prod_q <= prod_d;
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = prod_q;
  assign bus.rsp_id    = id_q;
  assign bus.issue_cnt = cnt_q;

endmodule

// File: tb/tb_ttest_mul_arb.sv
// Randomized + directed bench for ttest_mul_arb against a
// transaction-level reference model.
module tb_ttest_mul_arb;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ttest_mul_arb_if #(.NUM_REQ(N), .ID_W(2)) bus ();

  ttest_mul_arb #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  bit              m_init = 1'b0;
  bit              m_valid;
  longint unsigned m_data;
  int              m_id, m_ptr, m_cnt;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N] === 1'b1) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic longint unsigned opa(input int i);
    return longint'(bus.req_a[i*32 +: 32]);
  endfunction

  function automatic longint unsigned opb(input int i);
    return longint'(bus.req_b[i*8 +: 8]);
  endfunction

  // Reference model: one transaction per accepted request.
  int mg;
  always @(posedge clk) begin
    if (reset) begin
      m_init  = 1'b1;
      m_valid = 1'b0;
      m_ptr   = 0;
      m_cnt   = 0;
      m_id    = 0;
    end else if (m_init) begin
      if (!m_valid || bus.rsp_ready) begin
        mg = pick(m_ptr, bus.req_valid);
        if (mg >= 0) begin
          m_valid = 1'b1;
          m_data  = opa(mg) * opb(mg);
          m_id    = mg;
          m_ptr   = (mg + 1) % N;
          if (m_cnt < 65535) m_cnt++;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Compare process.
  int cg;
  logic [N-1:0] exp_rdy;
  always @(negedge clk) begin
    if (m_init) begin
      exp_rdy = '0;
      if (!reset && (!m_valid || bus.rsp_ready)) begin
        cg = pick(m_ptr, bus.req_valid);
        if (cg >= 0) exp_rdy[cg] = 1'b1;
      end
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
      chk("issue_cnt", 64'(bus.issue_cnt), 64'(m_cnt));
      if (m_valid) begin
        chk("rsp_data", 64'(bus.rsp_data), m_data);
        chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a,
                         input logic [7:0] b);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*8 +: 8]   = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++)
      set_ops(i, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
              ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom));
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    step();
    step();
    @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_cnt", 64'(bus.issue_cnt), 64'd0);

    // Single op on requester 1.
    step();
    reset         = 1'b0;
    bus.req_valid = 4'b0010;
    set_ops(1, 32'h0000_0003, 8'h05);
    @(negedge clk);
    chk("single_ready", 64'(bus.req_ready), 64'b0010);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_valid", 64'(bus.rsp_valid), 64'd1);
    chk("single_id", 64'(bus.rsp_id), 64'd1);
    chk("single_data", 64'(bus.rsp_data), 64'h0F);
    chk("single_ready0", 64'(bus.req_ready), 64'd0);

    // Maximum operands on requester 2.
    step();
    bus.req_valid = 4'b0100;
    set_ops(2, 32'hFFFF_FFFF, 8'hFF);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("max_data", 64'(bus.rsp_data), 64'hFE_FFFF_FF01);
    chk("max_id", 64'(bus.rsp_id), 64'd2);
    step();
    @(negedge clk);
    chk("bubble_valid", 64'(bus.rsp_valid), 64'd0);

    // Fairness from ptr=0 with everyone requesting.
    reset = 1'b1;
    step();
    reset         = 1'b0;
    bus.req_valid = '1;
    rand_ops();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fair_grant", 64'(bus.req_ready), 64'(1) << (k % N));
      if (k > 0) chk("fair_id", 64'(bus.rsp_id), 64'((k - 1) % N));
      step();
    end

    // Backpressure: last grant was 3, ptr back at 0.
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready", 64'(bus.req_ready), 64'd0);
      chk("bp_id", 64'(bus.rsp_id), 64'd3);
      chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
      step();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 64'(bus.req_ready), 64'b0001);
    step();
    @(negedge clk);
    chk("bp_next_id", 64'(bus.rsp_id), 64'd0);

    // Reset with an operation in flight.
    step();
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    reset         = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_cnt", 64'(bus.issue_cnt), 64'd0);
    step();
    @(negedge clk);
    chk("midrst_gone", 64'(bus.rsp_valid), 64'd0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      reset         = ($urandom_range(0, 99) == 0);
      bus.req_valid = N'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
    end

    // Counter saturation.
    step();
    reset = 1'b1;
    step();
    reset         = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    repeat (65540) step();
    @(negedge clk);
    chk("sat_cnt", 64'(bus.issue_cnt), 64'hFFFF);
    repeat (5) step();
    @(negedge clk);
    chk("sat_hold", 64'(bus.issue_cnt), 64'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
